// File: rtl/mips_pkg.sv
// Shared MIPS core constants: load-type encodings and register-file indices.
// Imported by the write-back load stage, its alignment helper and its interface.
package mips_pkg;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int REG_ZERO       = 0;

endpackage

// File: rtl/wb_load_stage_if.sv
// MEM -> WB bundle: control/data from the MEM stage and the registered WB outputs.
// master drives stall/flush and MEM-side fields; slave (the stage) drives wb_* and counters.
interface wb_load_stage_if
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = 16
);
    logic                  stall;
    logic                  flush;
    logic                  in_valid;
    logic                  mem_to_reg;
    logic [2:0]            load_type;
    logic [1:0]            addr_lo;
    logic [DATA_W-1:0]     read_data;
    logic [DATA_W-1:0]     alu_result;
    logic                  reg_write_in;
    logic [REG_ADDR_W-1:0] rd_in;
    logic                  wb_valid;
    logic [DATA_W-1:0]     wb_data;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_reg_write;
    logic                  misalign_err;
    logic [CNT_W-1:0]      load_count;

    modport master (
        output stall, flush, in_valid, mem_to_reg, load_type, addr_lo,
        output read_data, alu_result, reg_write_in, rd_in,
        input  wb_valid, wb_data, wb_rd, wb_reg_write, misalign_err, load_count
    );

    modport slave (
        input  stall, flush, in_valid, mem_to_reg, load_type, addr_lo,
        input  read_data, alu_result, reg_write_in, rd_in,
        output wb_valid, wb_data, wb_rd, wb_reg_write, misalign_err, load_count
    );

endinterface

// File: rtl/load_align.sv
// Combinational load extractor: picks byte/halfword lane, sign/zero-extends, flags misalignment.
// Ports: read_data, addr_lo, load_type in; data (extracted word), misalign out.
module load_align
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [DATA_W-1:0] read_data,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        load_type,
    output logic [DATA_W-1:0] data,
    output logic              misalign
);

    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Big-endian puts byte 0 in the top lane, so the lane index is 3 - addr_lo.
    assign byte_lane = BIG_ENDIAN ? ~addr_lo : addr_lo;
    assign half_lane = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
    assign byte_val  = read_data[{byte_lane, 3'b000} +: 8];
    assign half_val  = read_data[{half_lane, 4'b0000} +: 16];

    always_comb begin
        data     = read_data;
        misalign = 1'b0;
        case (load_type)
            LT_LW: begin
                misalign = (addr_lo != 2'b00);
            end
            LT_LB: begin
                data = {{(DATA_W-8){byte_val[7]}}, byte_val};
            end
            LT_LBU: begin
                data = {{(DATA_W-8){1'b0}}, byte_val};
            end
            LT_LH: begin
                data     = {{(DATA_W-16){half_val[15]}}, half_val};
                misalign = addr_lo[0];
            end
            LT_LHU: begin
                data     = {{(DATA_W-16){1'b0}}, half_val};
                misalign = addr_lo[0];
            end
            // Reserved encodings pass the word through but always fault.
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wb_load_stage.sv
// MEM/WB pipeline register: selects memory/ALU data, qualifies the write, counts loads.
// Ports: clk, rst (sync, active-high), bus (slave side of wb_load_stage_if).
module wb_load_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    wb_load_stage_if.slave   bus
);

    logic [DATA_W-1:0]     ext_data;
    logic                  ext_mis;
    logic                  is_load;
    logic                  mis;
    logic                  writes;

    logic                  valid_q;
    logic [DATA_W-1:0]     data_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  wr_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt_q;

    load_align #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .read_data (bus.read_data),
        .addr_lo   (bus.addr_lo),
        .load_type (bus.load_type),
        .data      (ext_data),
        .misalign  (ext_mis)
    );

    // Alignment only matters for real loads; ALU results never fault.
    assign is_load = bus.in_valid & bus.mem_to_reg;
    assign mis     = is_load & ext_mis;
    assign writes  = bus.in_valid & bus.reg_write_in
                   & (bus.rd_in != REG_ADDR_W'(REG_ZERO)) & ~mis;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (!bus.stall) begin
            valid_q <= bus.in_valid;
            data_q  <= bus.mem_to_reg ? ext_data : bus.alu_result;
            rd_q    <= bus.rd_in;
            wr_q    <= writes;
            err_q   <= mis;
            // Saturating: stops at all-ones instead of wrapping.
            if (is_load && !mis && !(&cnt_q)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.wb_valid     = valid_q;
    assign bus.wb_data      = data_q;
    assign bus.wb_rd        = rd_q;
    assign bus.wb_reg_write = wr_q;
    assign bus.misalign_err = err_q;
    assign bus.load_count   = cnt_q;

endmodule
